// File: rtl/fifo_pack_reader_pkg.sv
// Shared types and constants for the FIFO sample packer.
package fifo_pack_reader_pkg;

   typedef enum logic [1:0] {
      RUN   = 2'd0,
      DRAIN = 2'd1,
      EMIT  = 2'd2,
      DONE  = 2'd3
   } state_t;

   function automatic int unsigned cnt_width(input int unsigned pack);
      return $clog2(pack + 1);
   endfunction

   localparam int unsigned OUT_BUF_DEPTH = 2;
   localparam int unsigned OUT_BUF_CNT_W = cnt_width(OUT_BUF_DEPTH);

endpackage

// File: rtl/fifo_pack_reader_out_buf.sv
// Two-entry valid/ready skid buffer holding {count, packed word} entries.
module pack_out_buf
   import fifo_pack_reader_pkg::*;
#(
   parameter int unsigned ENTRY_W = 35
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     push,
   input  logic [ENTRY_W-1:0]       push_entry,
   output logic                     full,
   output logic [OUT_BUF_CNT_W-1:0] out_cnt,
   output logic                     out_valid,
   input  logic                     out_ready,
   output logic [ENTRY_W-1:0]       head
);

   logic [ENTRY_W-1:0] mem [OUT_BUF_DEPTH];
   logic               rd_ptr;
   logic               wr_ptr;
   logic               pop;

   assign out_valid = (out_cnt != '0);
   assign full      = (out_cnt == OUT_BUF_CNT_W'(OUT_BUF_DEPTH));
   assign pop       = out_valid & out_ready;
   assign head      = mem[rd_ptr];

   // Head entry only moves on pop, so it stays stable while stalled.
   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < OUT_BUF_DEPTH; i++) mem[i] <= '0;
         rd_ptr  <= 1'b0;
         wr_ptr  <= 1'b0;
         out_cnt <= '0;
      end else begin
         if (push) begin
            mem[wr_ptr] <= push_entry;
            wr_ptr      <= ~wr_ptr;
         end
         if (pop) rd_ptr <= ~rd_ptr;
         case ({push, pop})
            2'b10:   out_cnt <= out_cnt + OUT_BUF_CNT_W'(1);
            2'b01:   out_cnt <= out_cnt - OUT_BUF_CNT_W'(1);
            default: out_cnt <= out_cnt;
         endcase
      end
   end

endmodule

// File: rtl/fifo_pack_reader.sv
// Pops samples from the FIFO read port and packs PACK of them per output word.
// Define FIFO_PACK_READER_MSB_FIRST_EN to place the first sample in the top lane.
module fifo_pack_reader
   import fifo_pack_reader_pkg::*;
#(
   parameter int unsigned WIDTH = 8,
   parameter int unsigned PACK  = 4,
   parameter int unsigned CNT_W = cnt_width(PACK)
) (
   input  logic                  CLK,
   input  logic                  RST,
   output logic                  FIFO_RD,
   input  logic                  FIFO_EMPTY,
   input  logic [WIDTH-1:0]      FIFO_DATA,
   input  logic                  FLUSH,
   output logic                  FLUSH_DONE,
   output logic                  OUT_VALID,
   input  logic                  OUT_READY,
   output logic [WIDTH*PACK-1:0] OUT_DATA,
   output logic [CNT_W-1:0]      OUT_COUNT
);

   localparam int unsigned DATA_W  = WIDTH * PACK;
   localparam int unsigned ENTRY_W = CNT_W + DATA_W;

   state_t                   state;
   state_t                   state_next;
   logic [CNT_W-1:0]         filled;
   logic                     inflight;
   logic [DATA_W-1:0]        pack_reg;
   logic [DATA_W-1:0]        pack_next_c;
   logic [CNT_W-1:0]         lane_c;
   int unsigned              lane_base_c;
   logic [CNT_W:0]           level_c;
   logic                     land_last_c;
   logic                     emit_push_c;
   logic                     push_c;
   logic [ENTRY_W-1:0]       push_entry_c;
   logic [ENTRY_W-1:0]       head;
   logic                     full;
   logic [OUT_BUF_CNT_W-1:0] out_cnt;

`ifdef FIFO_PACK_READER_MSB_FIRST_EN
   assign lane_c = CNT_W'(PACK - 1) - filled;
`else
   assign lane_c = filled;
`endif

   assign level_c     = (CNT_W+1)'(filled) + (CNT_W+1)'(inflight);
   assign land_last_c = inflight & (filled == CNT_W'(PACK - 1));

   // Merge the landing sample into its lane.
   always_comb begin
      pack_next_c = pack_reg;
      lane_base_c = 32'(lane_c) * WIDTH;
      if (inflight) pack_next_c[lane_base_c +: WIDTH] = FIFO_DATA;
   end

   always_ff @(posedge CLK) begin
      if (RST) state <= RUN;
      else     state <= state_next;
   end

   // A pop that completes a word needs a free output slot when it lands.
   always_comb begin
      state_next  = state;
      FIFO_RD     = 1'b0;
      emit_push_c = 1'b0;
      FLUSH_DONE  = 1'b0;
      case (state)
         RUN: begin
            FIFO_RD = !RST && !FIFO_EMPTY &&
                      (!full || (level_c < (CNT_W+1)'(PACK - 1)));
            if (FLUSH) state_next = DRAIN;
         end
         DRAIN: begin
            if (!inflight) state_next = (filled != '0) ? EMIT : DONE;
         end
         EMIT: begin
            if (!full) begin
               emit_push_c = 1'b1;
               state_next  = DONE;
            end
         end
         DONE: begin
            FLUSH_DONE = 1'b1;
            state_next = RUN;
         end
         default: state_next = RUN;
      endcase
   end

   always_ff @(posedge CLK) begin
      if (RST) begin
         filled   <= '0;
         inflight <= 1'b0;
         pack_reg <= '0;
      end else begin
         inflight <= FIFO_RD;
         if (land_last_c || emit_push_c) begin
            filled   <= '0;
            pack_reg <= '0;
         end else if (inflight) begin
            filled   <= filled + CNT_W'(1);
            pack_reg <= pack_next_c;
         end
      end
   end

   assign push_c       = land_last_c | emit_push_c;
   assign push_entry_c = land_last_c ? {CNT_W'(PACK), pack_next_c} : {filled, pack_reg};

   pack_out_buf #(
      .ENTRY_W (ENTRY_W)
   ) u_out_buf (
      .clk        (CLK),
      .rst        (RST),
      .push       (push_c),
      .push_entry (push_entry_c),
      .full       (full),
      .out_cnt    (out_cnt),
      .out_valid  (OUT_VALID),
      .out_ready  (OUT_READY),
      .head       (head)
   );

   assign OUT_DATA  = head[DATA_W-1:0];
   assign OUT_COUNT = head[ENTRY_W-1:DATA_W];

endmodule

// File: tb/tb_fifo_pack_reader.sv
// Self-checking bench for fifo_pack_reader (WIDTH=8, PACK=4) with a small FIFO model.
`timescale 1ns/1ps
module tb_fifo_pack_reader;

   localparam int unsigned WIDTH = 8;
   localparam int unsigned PACK  = 4;

   logic        CLK = 1'b0;
   logic        RST;
   logic        FIFO_RD;
   logic        FIFO_EMPTY;
   logic [7:0]  FIFO_DATA;
   logic        FLUSH;
   logic        FLUSH_DONE;
   logic        OUT_VALID;
   logic        OUT_READY;
   logic [31:0] OUT_DATA;
   logic [2:0]  OUT_COUNT;

   fifo_pack_reader #(.WIDTH(WIDTH), .PACK(PACK)) dut (
      .CLK        (CLK),
      .RST        (RST),
      .FIFO_RD    (FIFO_RD),
      .FIFO_EMPTY (FIFO_EMPTY),
      .FIFO_DATA  (FIFO_DATA),
      .FLUSH      (FLUSH),
      .FLUSH_DONE (FLUSH_DONE),
      .OUT_VALID  (OUT_VALID),
      .OUT_READY  (OUT_READY),
      .OUT_DATA   (OUT_DATA),
      .OUT_COUNT  (OUT_COUNT)
   );

   always #5 CLK = ~CLK;

   // FIFO read-side model: data appears the cycle after the pop.
   logic [7:0]  mem [64];
   int unsigned wr_idx    = 0;
   int unsigned rd_idx    = 0;
   int unsigned pop_total = 0;

   assign FIFO_EMPTY = (rd_idx == wr_idx);

   always @(posedge CLK) begin
      if (RST) begin
         rd_idx <= wr_idx;
      end else if (FIFO_RD) begin
         FIFO_DATA <= mem[rd_idx % 64];
         rd_idx    <= rd_idx + 1;
         pop_total <= pop_total + 1;
      end
   end

   // Output collector.
   logic [31:0] q_data [$];
   logic [2:0]  q_cnt  [$];
   int unsigned done_total = 0;

   always @(negedge CLK) begin
      if (!RST && OUT_VALID && OUT_READY) begin
         q_data.push_back(OUT_DATA);
         q_cnt.push_back(OUT_COUNT);
      end
      if (!RST && FLUSH_DONE) done_total++;
   end

   int checks   = 0;
   int failures = 0;

   task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%h required=%h", nm, act, exp);
      end
   endtask

   task automatic cycles(input int n);
      repeat (n) @(posedge CLK);
      #1;
   endtask

   task automatic push_sample(input logic [7:0] s);
      mem[wr_idx % 64] = s;
      wr_idx++;
   endtask

   task automatic do_reset();
      RST       = 1'b1;
      FLUSH     = 1'b0;
      OUT_READY = 1'b0;
      cycles(2);
      check("rd_in_reset", {31'd0, FIFO_RD}, 32'd0);
      RST = 1'b0;
      q_data.delete();
      q_cnt.delete();
      @(negedge CLK);
      check("rst_valid", {31'd0, OUT_VALID}, 32'd0);
      check("rst_data", OUT_DATA, 32'd0);
      check("rst_count", {29'd0, OUT_COUNT}, 32'd0);
      check("rst_flush_done", {31'd0, FLUSH_DONE}, 32'd0);
      cycles(1);
   endtask

   task automatic wait_words(input int n, input int budget);
      for (int k = 0; k < budget && q_data.size() < n; k++) cycles(1);
      check("words_avail", q_data.size(), n);
   endtask

   task automatic get_word(output logic [31:0] d, output logic [2:0] c);
      if (q_data.size() > 0) begin
         d = q_data.pop_front();
         c = q_cnt.pop_front();
      end else begin
         d = 'x;
         c = 'x;
      end
   endtask

   function automatic logic [31:0] exp_word(input logic [7:0] b);
`ifdef FIFO_PACK_READER_MSB_FIRST_EN
      return {b, b + 8'd1, b + 8'd2, b + 8'd3};
`else
      return {b + 8'd3, b + 8'd2, b + 8'd1, b};
`endif
   endfunction

   typedef struct {
      int unsigned n;
      logic [31:0] smp;
      logic        fl;
      logic [31:0] exp_lsb;
      logic [31:0] exp_msb;
      logic [2:0]  exp_cnt;
   } vec_t;

   vec_t        vt [6];
   logic [31:0] d;
   logic [2:0]  c;
   logic [31:0] exp_d;
   logic [31:0] held;
   logic [5:0]  pat;
   int          first_rd, first_v, run, max_run;
   int unsigned base, d0;
   bit          stable, seen;

   initial begin
      vt[0] = '{4, 32'h04030201, 1'b0, 32'h04030201, 32'h01020304, 3'd4};
      vt[1] = '{3, 32'h00A3A2A1, 1'b1, 32'h00A3A2A1, 32'hA1A2A300, 3'd3};
      vt[2] = '{2, 32'h0000A2A1, 1'b1, 32'h0000A2A1, 32'hA1A20000, 3'd2};
      vt[3] = '{1, 32'h0000005A, 1'b1, 32'h0000005A, 32'h5A000000, 3'd1};
      vt[4] = '{4, 32'hCCDDEEFF, 1'b0, 32'hCCDDEEFF, 32'hFFEEDDCC, 3'd4};
      vt[5] = '{4, 32'h80402010, 1'b1, 32'h80402010, 32'h10204080, 3'd4};

      do_reset();

      // Table: whole words and flushed partial words.
      OUT_READY = 1'b1;
      for (int i = 0; i < 6; i++) begin
         d0 = done_total;
         for (int j = 0; j < vt[i].n; j++) push_sample(vt[i].smp[j*8 +: 8]);
         cycles(8);
         if (vt[i].fl) begin
            FLUSH = 1'b1;
            cycles(1);
            FLUSH = 1'b0;
         end
         wait_words(1, 20);
         get_word(d, c);
`ifdef FIFO_PACK_READER_MSB_FIRST_EN
         exp_d = vt[i].exp_msb;
`else
         exp_d = vt[i].exp_lsb;
`endif
         check($sformatf("vec%0d_data", i), d, exp_d);
         check($sformatf("vec%0d_count", i), {29'd0, c}, {29'd0, vt[i].exp_cnt});
         cycles(4);
         check($sformatf("vec%0d_flush_done", i), done_total - d0, {31'd0, vt[i].fl});
         check($sformatf("vec%0d_extra_words", i), q_data.size(), 0);
      end

      // Eight preloaded samples streamed with the consumer always ready.
      do_reset();
      OUT_READY = 1'b1;
      for (int j = 1; j <= 8; j++) push_sample(8'(j));
      first_rd = -1; first_v = -1; run = 0; max_run = 0;
      for (int k = 0; k < 20; k++) begin
         @(negedge CLK);
         if (FIFO_RD) begin
            if (first_rd < 0) first_rd = k;
            run++;
            if (run > max_run) max_run = run;
         end else begin
            run = 0;
         end
         if (OUT_VALID && first_v < 0) first_v = k;
      end
      cycles(1);
      check("stream_rd_run", max_run, 8);
      check("stream_first_latency", first_v - first_rd, 5);
      check("stream_words", q_data.size(), 2);
      for (int w = 0; w < 2; w++) begin
         get_word(d, c);
         check($sformatf("stream_word%0d", w), d, exp_word(8'(1 + 4*w)));
         check($sformatf("stream_count%0d", w), {29'd0, c}, 32'd4);
      end

      // Consumer stalled with 16 samples available.
      do_reset();
      OUT_READY = 1'b0;
      base = pop_total;
      for (int j = 1; j <= 16; j++) push_sample(8'(j));
      stable = 1'b1; seen = 1'b0; held = '0;
      for (int k = 0; k < 25; k++) begin
         @(negedge CLK);
         if (OUT_VALID) begin
            if (!seen) begin
               held = OUT_DATA;
               seen = 1'b1;
            end else if (OUT_DATA !== held) begin
               stable = 1'b0;
            end
         end
      end
      cycles(1);
      check("stall_pops", pop_total - base, 11);
      check("stall_valid", {31'd0, OUT_VALID}, 32'd1);
      check("stall_head", held, exp_word(8'd1));
      check("stall_data_stable", {31'd0, stable}, 32'd1);
      check("stall_no_xfer", q_data.size(), 0);
      OUT_READY = 1'b1;
      wait_words(4, 40);
      for (int w = 0; w < 4; w++) begin
         get_word(d, c);
         check($sformatf("stall_word%0d", w), d, exp_word(8'(1 + 4*w)));
         check($sformatf("stall_count%0d", w), {29'd0, c}, 32'd4);
      end
      check("stall_total_pops", pop_total - base, 16);

      // Flush with nothing packed; a second FLUSH during DRAIN must be ignored.
      do_reset();
      OUT_READY = 1'b1;
      d0  = done_total;
      pat = 6'b000100;
      for (int k = 0; k < 6; k++) begin
         FLUSH = (k < 2);
         @(negedge CLK);
         check($sformatf("empty_flush_done_c%0d", k), {31'd0, FLUSH_DONE}, {31'd0, pat[k]});
         check($sformatf("empty_flush_valid_c%0d", k), {31'd0, OUT_VALID}, 32'd0);
         @(posedge CLK);
         #1;
      end
      FLUSH = 1'b0;
      cycles(2);
      check("empty_flush_pulses", done_total - d0, 1);

      // FLUSH in the same cycle as the second pop: that sample is still packed.
      do_reset();
      OUT_READY = 1'b1;
      push_sample(8'hB1);
      push_sample(8'hB2);
      cycles(1);
      FLUSH = 1'b1;
      cycles(1);
      FLUSH = 1'b0;
      wait_words(1, 20);
      get_word(d, c);
`ifdef FIFO_PACK_READER_MSB_FIRST_EN
      check("pop_flush_data", d, 32'hB1B20000);
`else
      check("pop_flush_data", d, 32'h0000B2B1);
`endif
      check("pop_flush_count", {29'd0, c}, 32'd2);

      // Reset with two words buffered and a pop in flight.
      do_reset();
      OUT_READY = 1'b0;
      base = pop_total;
      for (int j = 1; j <= 16; j++) push_sample(8'(j));
      for (int k = 0; k < 40; k++) begin
         cycles(1);
         if (pop_total - base >= 10) break;
      end
      check("pre_reset_pops", pop_total - base, 10);
      RST = 1'b1;
      @(negedge CLK);
      check("pre_reset_valid", {31'd0, OUT_VALID}, 32'd1);
      check("rd_forced_low", {31'd0, FIFO_RD}, 32'd0);
      @(posedge CLK);
      #1;
      RST = 1'b0;
      @(negedge CLK);
      check("post_reset_valid", {31'd0, OUT_VALID}, 32'd0);
      check("post_reset_rd", {31'd0, FIFO_RD}, 32'd0);
      check("post_reset_data", OUT_DATA, 32'd0);
      check("post_reset_count", {29'd0, OUT_COUNT}, 32'd0);
      cycles(1);
      check("post_reset_no_xfer", q_data.size(), 0);
      OUT_READY = 1'b1;
      for (int j = 0; j < 4; j++) push_sample(8'(8'h31 + j));
      wait_words(1, 20);
      get_word(d, c);
      check("post_reset_word", d, exp_word(8'h31));
      check("post_reset_word_count", {29'd0, c}, 32'd4);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog expired checks=%0d failures=%0d", checks, failures);
      $fatal(1);
   end

endmodule
